// File: rtl/snake_game_sequencer_pkg.sv
// Shared definitions for the snake game sequencer: FSM states, direction
// codes and the externally visible o_State codes.
package snake_game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PLAY,
        ST_WAIT_BLANK,
        ST_STEP,
        ST_OVER
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [1:0] OST_IDLE  = 2'b00;
    localparam logic [1:0] OST_PLAY  = 2'b01;
    localparam logic [1:0] OST_OVER  = 2'b10;
    localparam logic [1:0] OST_CLEAR = 2'b11;

    // WAIT_BLANK and STEP are internal sub-phases of PLAY.
    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            ST_IDLE:  return OST_IDLE;
            ST_CLEAR: return OST_CLEAR;
            ST_OVER:  return OST_OVER;
            default:  return OST_PLAY;
        endcase
    endfunction

    // Opposite directions differ only in the low bit.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_dir_buffer.sv
// Button edge detection and next-direction buffer. Rising edges are
// prioritised Up > Down > Left > Right; a press that would reverse the
// committed direction is dropped and leaves the buffer unchanged.
module snake_dir_buffer
    import snake_game_sequencer_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic up_i,
    input  logic down_i,
    input  logic left_i,
    input  logic right_i,
    input  dir_t cur_dir_i,
    input  logic reload_i,
    output dir_t next_dir_o,
    output logic any_rise_o
);

    logic [3:0] btn_q;
    logic [3:0] btn_d;
    logic [3:0] rise;
    logic       cand_valid;
    dir_t       cand;
    dir_t       next_dir_q;
    dir_t       next_dir_d;

    // Edge detect, priority pick and anti-reversal filter.
    always_comb begin
        btn_d      = {up_i, down_i, left_i, right_i};
        rise       = btn_d & ~btn_q;
        cand_valid = |rise;
        cand       = DIR_RIGHT;
        if (rise[3])      cand = DIR_UP;
        else if (rise[2]) cand = DIR_DOWN;
        else if (rise[1]) cand = DIR_LEFT;
        next_dir_d = next_dir_q;
        if (reload_i)
            next_dir_d = DIR_RIGHT;
        else if (cand_valid && (cand != reverse_dir(cur_dir_i)))
            next_dir_d = cand;
    end

    // Previous button levels and the buffered direction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_q      <= '0;
            next_dir_q <= DIR_RIGHT;
        end else begin
            btn_q      <= btn_d;
            next_dir_q <= next_dir_d;
        end
    end

    assign next_dir_o = next_dir_q;
    assign any_rise_o = cand_valid;

endmodule

// File: rtl/snake_game_sequencer.sv
// Game-level controller for the snake VGA design: IDLE/CLEAR/PLAY/OVER flow,
// tick division, vertical-blank step scheduling with a done timeout, and score.
// Optional build macro SNAKE_SPEEDUP_EN: every FOOD_PER_LVL foods the step
// divider shrinks by one (floor 1); without it the divider is fixed.
module snake_game_sequencer
    import snake_game_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV_INIT = 4,
    parameter int unsigned STEP_TIMEOUT  = 1023,
    parameter int unsigned FOOD_PER_LVL  = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Game_Tick,
    input  logic       i_VBlank,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Left,
    input  logic       i_Right,
    input  logic       i_Clear_Done,
    input  logic       i_Step_Done,
    input  logic       i_Collision,
    input  logic       i_Food_Eaten,
    output logic       o_Clear_Req,
    output logic       o_Step_Req,
    output logic [1:0] o_Dir,
    output logic       o_Grow,
    output logic [1:0] o_State,
    output logic [7:0] o_Score
);

    if (TICK_DIV_INIT < 1 || TICK_DIV_INIT > 15 || FOOD_PER_LVL < 1 || STEP_TIMEOUT < 2) begin : g_bad_cfg
        $error("snake_game_sequencer: parameter out of range");
    end

    localparam logic [3:0]              DIV_INIT = 4'(TICK_DIV_INIT);
    localparam int unsigned             TMR_W    = $clog2(STEP_TIMEOUT);
    localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(STEP_TIMEOUT - 1);

    state_t           state_q;
    dir_t             dir_q;
    dir_t             next_dir;
    logic             any_rise;
    logic             game_start;
    logic             clear_req_q;
    logic             step_req_q;
    logic             grow_q;
    logic             armed_q;
    logic [7:0]       score_q;
    logic [3:0]       div_q;
    logic [TMR_W-1:0] timer_q;
    logic [3:0]       reload_now;
    logic [3:0]       reload_next;

    assign game_start = (state_q == ST_CLEAR) && i_Clear_Done;

    snake_dir_buffer u_dir_buffer (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst_L),
        .up_i       (i_Up),
        .down_i     (i_Down),
        .left_i     (i_Left),
        .right_i    (i_Right),
        .cur_dir_i  (dir_q),
        .reload_i   (game_start),
        .next_dir_o (next_dir),
        .any_rise_o (any_rise)
    );

`ifdef SNAKE_SPEEDUP_EN
    localparam int unsigned      LVL_W    = $clog2(FOOD_PER_LVL + 1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(FOOD_PER_LVL - 1);

    logic [3:0]       reload_q;
    logic [3:0]       reload_d;
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_d;
    logic             food_step;

    // Level counter: each completed level shortens the step divider.
    always_comb begin
        food_step = (state_q == ST_STEP) && i_Step_Done && !i_Collision && i_Food_Eaten;
        reload_d  = reload_q;
        lvl_d     = lvl_q;
        if (game_start) begin
            reload_d = DIV_INIT;
            lvl_d    = '0;
        end else if (food_step) begin
            if (lvl_q == LVL_LAST) begin
                lvl_d = '0;
                if (reload_q > 4'd1) reload_d = reload_q - 4'd1;
            end else begin
                lvl_d = lvl_q + LVL_W'(1);
            end
        end
    end

    // Level and reload registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            reload_q <= DIV_INIT;
            lvl_q    <= '0;
        end else begin
            reload_q <= reload_d;
            lvl_q    <= lvl_d;
        end
    end

    assign reload_now  = reload_q;
    assign reload_next = reload_d;
`else
    assign reload_now  = DIV_INIT;
    assign reload_next = DIV_INIT;
`endif

    // Game flow FSM with registered request, pulse, direction and score outputs.
    // The divider is reloaded when a step completes so a new speed level takes
    // effect on the very next step; ticks outside PLAY never reach it.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_RIGHT;
            clear_req_q <= 1'b0;
            step_req_q  <= 1'b0;
            grow_q      <= 1'b0;
            armed_q     <= 1'b0;
            score_q     <= '0;
            div_q       <= DIV_INIT;
            timer_q     <= '0;
        end else begin
            grow_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_rise) begin
                        state_q     <= ST_CLEAR;
                        clear_req_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (i_Clear_Done) begin
                        clear_req_q <= 1'b0;
                        state_q     <= ST_PLAY;
                        score_q     <= '0;
                        dir_q       <= DIR_RIGHT;
                        div_q       <= DIV_INIT;
                    end
                end
                ST_PLAY: begin
                    if (i_Game_Tick) begin
                        if (div_q <= 4'd1) begin
                            div_q   <= reload_now;
                            state_q <= ST_WAIT_BLANK;
                        end else begin
                            div_q <= div_q - 4'd1;
                        end
                    end
                end
                ST_WAIT_BLANK: begin
                    if (i_VBlank) begin
                        dir_q      <= next_dir;
                        step_req_q <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (i_Step_Done) begin
                        step_req_q <= 1'b0;
                        if (i_Collision) begin
                            state_q <= ST_OVER;
                            armed_q <= 1'b0;
                        end else begin
                            state_q <= ST_PLAY;
                            div_q   <= reload_next;
                            if (i_Food_Eaten) begin
                                grow_q <= 1'b1;
                                if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                            end
                        end
                    end else if (timer_q == TMR_LAST) begin
                        step_req_q <= 1'b0;
                        state_q    <= ST_OVER;
                        armed_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_OVER: begin
                    if (!armed_q) begin
                        if (i_Game_Tick) armed_q <= 1'b1;
                    end else if (any_rise) begin
                        state_q     <= ST_CLEAR;
                        clear_req_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Clear_Req = clear_req_q;
    assign o_Step_Req  = step_req_q;
    assign o_Dir       = dir_q;
    assign o_Grow      = grow_q;
    assign o_State     = state_code(state_q);
    assign o_Score     = score_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Testbench for snake_game_sequencer: directed scenarios plus randomized games
// checked against a transaction-level model of score, direction and speed.
module tb_snake_game_sequencer;

    localparam int unsigned TICK_DIV_INIT = 4;
    localparam int unsigned STEP_TIMEOUT  = 1023;
    localparam int unsigned FOOD_PER_LVL  = 4;

    logic clk, rst_n, tick, vblank, b_up, b_down, b_left, b_right;
    logic clr_done, stp_done, coll, food;
    logic clear_req, step_req, grow;
    logic [1:0] dir, state;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;

    // Reference model
    int m_dir, m_next, m_score, m_reload, m_foods;

    snake_game_sequencer #(
        .TICK_DIV_INIT (TICK_DIV_INIT),
        .STEP_TIMEOUT  (STEP_TIMEOUT),
        .FOOD_PER_LVL  (FOOD_PER_LVL)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Game_Tick  (tick),
        .i_VBlank     (vblank),
        .i_Up         (b_up),
        .i_Down       (b_down),
        .i_Left       (b_left),
        .i_Right      (b_right),
        .i_Clear_Done (clr_done),
        .i_Step_Done  (stp_done),
        .i_Collision  (coll),
        .i_Food_Eaten (food),
        .o_Clear_Req  (clear_req),
        .o_Step_Req   (step_req),
        .o_Dir        (dir),
        .o_Grow       (grow),
        .o_State      (state),
        .o_Score      (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        {tick, vblank, b_up, b_down, b_left, b_right} = '0;
        {clr_done, stp_done, coll, food} = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Press/release a button mask {up,down,left,right} and update the model.
    task automatic press(input logic [3:0] m);
        int c;
        {b_up, b_down, b_left, b_right} = m;
        cyc(1);
        {b_up, b_down, b_left, b_right} = 4'b0000;
        cyc(1);
        if (m[3]) c = 0; else if (m[2]) c = 1; else if (m[1]) c = 2; else c = 3;
        if (m != 4'b0000 && c != (m_dir ^ 1)) m_next = c;
    endtask

    task automatic start_game();
        bit seen;
        seen = 1'b0;
        {b_up, b_down, b_left, b_right} = 4'b1000;
        cyc(1);
        {b_up, b_down, b_left, b_right} = 4'b0000;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (state === 2'b11) seen = 1'b1; else cyc(1);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL start_enter_clear: state=%b want 11", state); end
        cyc(5);
        checks++;
        if (clear_req !== 1'b1) begin errors++; $display("FAIL clear_req_held: got %b want 1", clear_req); end
        clr_done = 1'b1;
        cyc(1);
        clr_done = 1'b0;
        checks++;
        if (state !== 2'b01 || clear_req !== 1'b0 || dir !== 2'b11 || score !== 8'd0) begin
            errors++;
            $display("FAIL start_play: state=%b clr=%b dir=%b score=%0d want 01/0/11/0", state, clear_req, dir, score);
        end
        m_dir = 3; m_next = 3; m_score = 0; m_reload = TICK_DIV_INIT; m_foods = 0;
    endtask

    // Feed exactly the model's tick count, hold off VBlank, then expect a step request.
    task automatic trigger_step(input int vb_delay, input bit extra);
        vblank = 1'b0;
        for (int t = 0; t < m_reload; t++) begin
            checks++;
            if (state !== 2'b01 || step_req !== 1'b0) begin
                errors++;
                $display("FAIL pre_tick %0d: state=%b req=%b want 01/0", t, state, step_req);
            end
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
        for (int i = 0; i < vb_delay; i++) begin
            tick = extra; stp_done = extra;
            cyc(1);
            tick = 1'b0; stp_done = 1'b0;
        end
        checks++;
        if (step_req !== 1'b0) begin errors++; $display("FAIL req_before_vblank: got %b want 0", step_req); end
        vblank = 1'b1;
        cyc(1);
        checks++;
        if (step_req !== 1'b1) begin errors++; $display("FAIL req_in_vblank: got %b want 1", step_req); end
        checks++;
        if (dir !== 2'(m_next)) begin errors++; $display("FAIL dir_commit: got %b want %b", dir, 2'(m_next)); end
        m_dir = m_next;
    endtask

    task automatic finish_step(input bit f, input bit c, input int hold, input bit extra);
        for (int i = 0; i < hold; i++) begin
            tick = extra;
            cyc(1);
            tick = 1'b0;
        end
        checks++;
        if (step_req !== 1'b1) begin errors++; $display("FAIL req_held: got %b want 1", step_req); end
        stp_done = 1'b1; food = f; coll = c;
        cyc(1);
        stp_done = 1'b0; food = 1'b0; coll = 1'b0;
        if (f && !c) begin
            if (m_score < 255) m_score++;
            m_foods++;
`ifdef SNAKE_SPEEDUP_EN
            if (m_foods % FOOD_PER_LVL == 0 && m_reload > 1) m_reload--;
`endif
        end
        checks++;
        if (step_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", step_req); end
        checks++;
        if (grow !== (f && !c)) begin errors++; $display("FAIL grow_pulse: got %b want %b", grow, f && !c); end
        checks++;
        if (state !== (c ? 2'b10 : 2'b01)) begin errors++; $display("FAIL post_step_state: got %b want %b", state, c ? 2'b10 : 2'b01); end
        checks++;
        if (score !== 8'(m_score)) begin errors++; $display("FAIL score: got %0d want %0d", score, m_score); end
        cyc(1);
        checks++;
        if (grow !== 1'b0) begin errors++; $display("FAIL grow_single: got %b want 0", grow); end
        vblank = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (clear_req !== 1'b0 || step_req !== 1'b0 || grow !== 1'b0 || dir !== 2'b11 || state !== 2'b00 || score !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: clr=%b req=%b grow=%b dir=%b state=%b score=%0d want 0/0/0/11/00/0", clear_req, step_req, grow, dir, state, score);
        end
    endtask

    task automatic test_idle_ignores();
        {tick, clr_done, stp_done, vblank} = 4'b1111;
        cyc(1);
        {tick, clr_done, stp_done, vblank} = 4'b0000;
        cyc(2);
        checks++;
        if (state !== 2'b00 || clear_req !== 1'b0 || step_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores: state=%b clr=%b req=%b want 00/0/0", state, clear_req, step_req);
        end
    endtask

    task automatic test_direction();
        apply_reset();
        start_game();
        press(4'b0010);
        trigger_step(0, 1'b0);
        checks++;
        if (dir !== 2'b11) begin errors++; $display("FAIL reverse_reject: got %b want 11", dir); end
        finish_step(1'b0, 1'b0, 0, 1'b0);
        press(4'b1010);
        trigger_step(1, 1'b0);
        checks++;
        if (dir !== 2'b00) begin errors++; $display("FAIL up_priority: got %b want 00", dir); end
        finish_step(1'b0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_tick_divider();
        int nreq;
        bit prev;
        apply_reset();
        start_game();
        nreq = 0; prev = 1'b0;
        vblank = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (step_req === 1'b1) begin
                    if (!prev) nreq++;
                    prev = 1'b1;
                    stp_done = 1'b1;
                    cyc(1);
                    stp_done = 1'b0;
                end else begin
                    prev = 1'b0;
                    cyc(1);
                end
            end
        end
        vblank = 1'b0;
        checks++;
        if (nreq != 2) begin errors++; $display("FAIL tick_divider: got %0d step requests want 2", nreq); end
    endtask

    task automatic test_food_score();
        apply_reset();
        start_game();
        for (int i = 0; i < 3; i++) begin
            trigger_step(i, 1'b1);
            finish_step(1'b1, 1'b0, i, 1'b1);
        end
        checks++;
        if (score !== 8'd3) begin errors++; $display("FAIL score_three: got %0d want 3", score); end
        trigger_step(0, 1'b0);
        finish_step(1'b1, 1'b1, 0, 1'b0);
        checks++;
        if (state !== 2'b10 || score !== 8'd3) begin errors++; $display("FAIL food_collision: state=%b score=%0d want 10/3", state, score); end
    endtask

    task automatic test_over_restart();
        press(4'b0100);
        cyc(2);
        checks++;
        if (state !== 2'b10) begin errors++; $display("FAIL over_guard: got %b want 10", state); end
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
        press(4'b0001);
        checks++;
        if (state !== 2'b11 || clear_req !== 1'b1 || score !== 8'd3) begin
            errors++;
            $display("FAIL over_restart: state=%b clr=%b score=%0d want 11/1/3", state, clear_req, score);
        end
        clr_done = 1'b1;
        cyc(1);
        clr_done = 1'b0;
        checks++;
        if (state !== 2'b01 || score !== 8'd0 || dir !== 2'b11) begin
            errors++;
            $display("FAIL restart_play: state=%b score=%0d dir=%b want 01/0/11", state, score, dir);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        start_game();
        trigger_step(0, 1'b0);
        cyc(STEP_TIMEOUT - 1);
        checks++;
        if (step_req !== 1'b1 || state !== 2'b01) begin errors++; $display("FAIL timeout_early: req=%b state=%b want 1/01", step_req, state); end
        cyc(1);
        checks++;
        if (step_req !== 1'b0 || state !== 2'b10) begin errors++; $display("FAIL timeout: req=%b state=%b want 0/10", step_req, state); end
        vblank = 1'b0;
    endtask

    task automatic test_async_reset_mid_step();
        apply_reset();
        start_game();
        trigger_step(0, 1'b0);
        finish_step(1'b1, 1'b0, 0, 1'b0);
        press(4'b1000);
        trigger_step(0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (step_req !== 1'b0 || state !== 2'b00 || score !== 8'd0 || dir !== 2'b11) begin
            errors++;
            $display("FAIL async_reset: req=%b state=%b score=%0d dir=%b want 0/00/0/11", step_req, state, score, dir);
        end
        vblank = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_score_saturation();
        apply_reset();
        start_game();
        for (int i = 0; i < 257; i++) begin
            trigger_step(0, 1'b0);
            finish_step(1'b1, 1'b0, 0, 1'b0);
        end
        checks++;
        if (score !== 8'd255) begin errors++; $display("FAIL score_saturate: got %0d want 255", score); end
    endtask

    task automatic test_random();
        for (int g = 0; g < 4; g++) begin
            apply_reset();
            start_game();
            for (int s = 0; s < 15; s++) begin
                bit f, c;
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) press(4'($urandom_range(1, 15)));
                trigger_step($urandom_range(0, 3), 1'($urandom_range(0, 1)));
                f = 1'($urandom_range(0, 1));
                c = ($urandom_range(0, 9) == 0);
                finish_step(f, c, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                if (c) break;
            end
        end
    endtask

`ifdef SNAKE_SPEEDUP_EN
    task automatic test_speedup();
        apply_reset();
        start_game();
        for (int i = 0; i < 4; i++) begin
            trigger_step(0, 1'b0);
            finish_step(1'b1, 1'b0, 0, 1'b0);
        end
        vblank = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick = 1'b1; cyc(1); tick = 1'b0; cyc(2);
        end
        checks++;
        if (step_req !== 1'b0) begin errors++; $display("FAIL speedup_early: got %b want 0", step_req); end
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
        checks++;
        if (step_req !== 1'b1) begin errors++; $display("FAIL speedup_step: got %b want 1", step_req); end
        finish_step(1'b0, 1'b0, 0, 1'b0);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        {tick, vblank, b_up, b_down, b_left, b_right} = '0;
        {clr_done, stp_done, coll, food} = '0;
        m_dir = 3; m_next = 3; m_score = 0; m_reload = TICK_DIV_INIT; m_foods = 0;
        test_reset();
        test_idle_ignores();
        start_game();
        test_direction();
        test_tick_divider();
        test_food_score();
        test_over_restart();
        test_timeout();
        test_async_reset_mid_step();
        test_score_saturation();
        test_random();
`ifdef SNAKE_SPEEDUP_EN
        test_speedup();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
